// File: rtl/uart_tx_queue.sv
// Byte FIFO and launch sequencer feeding a UART transmitter over a tx_start/tx_data/tx_idle handshake.
// Define UART_TXQ_OVERFLOW_EN to add the sticky overflow flag and its ovf_clr input.
module uart_tx_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
`ifdef UART_TXQ_OVERFLOW_EN
  input  logic              ovf_clr,
  output logic              overflow,
`endif
  input  logic              tx_idle
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_IDLE
  } state_t;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  state_t            state_q, state_d;
  logic              push;
  logic              pop;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign busy     = (count_q != '0) || (state_q != S_IDLE);
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

  assign push = wr_en && !full;

  // A pop only happens on the idle-to-launch transition, so it is decided here.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && tx_idle) begin
          pop     = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH:    state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!tx_idle) state_d = S_WAIT_IDLE;
      S_WAIT_IDLE: if (tx_idle) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
    tx_start_d = (state_d == S_LAUNCH);
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  // Storage deliberately has no reset; the pointers and count define what is valid.
  always_ff @(posedge CLK100MHZ) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef UART_TXQ_OVERFLOW_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule
